// File: rtl/inst_mem_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port used by inst_mem_loader.
// master = loader side, slave = byte source / memory side.
interface inst_mem_loader_if #(
  parameter int unsigned AW = 8
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Loads a checksummed big-endian word image from a byte stream into instruction memory
// and holds the core in reset until a complete, valid image has been written.
module inst_mem_loader #(
  parameter int unsigned INST_DEPTH = 256
) (
  input  logic                clk,
  input  logic                resetpc,
  input  logic                start,
  inst_mem_loader_if.master   bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int unsigned AW = $clog2(INST_DEPTH);
  localparam logic [16:0] DepthLimit = 17'(INST_DEPTH);

  typedef enum logic [2:0] {
    StIdle, StHdrHi, StHdrLo, StData, StCsum, StDone, StErr
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    acc_q, acc_d;
  logic [23:0]   word_q, word_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic          xfer;
  logic [15:0]   hdr_count;
  logic [31:0]   word_full;

  assign busy     = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                    (state_q == StData)  || (state_q == StCsum);
  assign done     = (state_q == StDone);
  assign err      = (state_q == StErr);
  assign cpu_hold = (state_q != StDone);
  assign xfer     = bus.rx_valid & busy;

  assign bus.rx_ready  = busy;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    acc_d       = acc_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hdr_count   = {count_q[15:8], bus.rx_data};
    word_full   = {word_q, bus.rx_data};

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StHdrHi;
          word_idx_d = '0;
          byte_idx_d = '0;
          acc_d      = '0;
        end
      end
      StHdrHi: begin
        if (xfer) begin
          count_d[15:8] = bus.rx_data;
          state_d       = StHdrLo;
        end
      end
      StHdrLo: begin
        if (xfer) begin
          count_d = hdr_count;
          if ({1'b0, hdr_count} > DepthLimit) begin
            state_d = StErr;
          end else if (hdr_count == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          word_d     = word_full[23:0];
          acc_d      = acc_q + bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          // Fourth byte completes a word: register the write so it pulses next cycle.
          if (byte_idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_idx_q[AW-1:0];
            mem_wdata_d = word_full;
            word_idx_d  = word_idx_q + 16'd1;
            if (word_idx_q == count_q - 16'd1) begin
              state_d = StCsum;
            end
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          state_d = (bus.rx_data == acc_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetpc) begin
      state_q     <= StIdle;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      acc_q       <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      acc_q       <= acc_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: frame loads, checksum/header errors, throttling,
// mid-session reset and restart behaviour.
module tb_inst_mem_loader;
  localparam int unsigned INST_DEPTH = 256;

  logic clk = 1'b0;
  logic resetpc = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, busy, done, err;
  int checks = 0;
  int failures = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  inst_mem_loader_if #(.AW(8)) bus();

  inst_mem_loader #(.INST_DEPTH(INST_DEPTH)) dut (
    .clk(clk), .resetpc(resetpc), .start(start), .bus(bus.master),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      ok = (bus.rx_ready === 1'b1);
      @(posedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: byte %h not accepted, rx_ready=%b want 1", b, bus.rx_ready);
    end
  endtask

  task automatic send_bytes(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    resetpc = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetpc = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rx_ready !== 1'b0) begin failures++; $display("FAIL rst_rx_ready got=%b want=0", bus.rx_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_cpu_hold got=%b want=1", cpu_hold); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_flags done=%b err=%b want 0 0", done, err); end
    checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL rst_writes got=%0d want=0", wr_addr.size()); end
    checks++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem addr=%h data=%h want 0 0", bus.mem_addr, bus.mem_wdata); end
    idle(1);
  endtask

  task automatic test_two_word();
    logic [7:0] f[$];
    pulse_start();
    checks++; if (busy !== 1'b1 || bus.rx_ready !== 1'b1) begin failures++; $display("FAIL tw_start busy=%b rdy=%b want 1 1", busy, bus.rx_ready); end
    f = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h39};
    send_bytes(f);
    idle(2);
    checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL tw_nwrites got=%0d want=2", wr_addr.size()); end
    checks++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h20080005) begin failures++; $display("FAIL tw_w0 addr=%h data=%h want 00 20080005", wr_addr[0], wr_data[0]); end
    checks++; if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h0000000C) begin failures++; $display("FAIL tw_w1 addr=%h data=%h want 01 0000000c", wr_addr[1], wr_data[1]); end
    checks++; if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL tw_status done=%b err=%b hold=%b want 1 0 0", done, err, cpu_hold); end
    checks++; if (bus.rx_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL tw_idle rdy=%b busy=%b want 0 0", bus.rx_ready, busy); end
  endtask

  task automatic test_bad_csum();
    logic [7:0] f[$];
    pulse_start();
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL bc_start done=%b hold=%b want 0 1", done, cpu_hold); end
    f = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h38};
    send_bytes(f);
    idle(2);
    checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL bc_nwrites got=%0d want=2", wr_addr.size()); end
    checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL bc_status err=%b done=%b hold=%b want 1 0 1", err, done, cpu_hold); end
  endtask

  task automatic test_oversize();
    logic [7:0] f[$];
    pulse_start();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ov_err_clear got=%b want=0", err); end
    f = {8'h01, 8'h01};
    send_bytes(f);
    idle(2);
    checks++; if (err !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ov_status err=%b done=%b want 1 0", err, done); end
    checks++; if (bus.rx_ready !== 1'b0) begin failures++; $display("FAIL ov_rx_ready got=%b want=0", bus.rx_ready); end
    checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL ov_nwrites got=%0d want=0", wr_addr.size()); end
  endtask

  task automatic test_empty();
    logic [7:0] f[$];
    pulse_start();
    f = {8'h00, 8'h00, 8'h00};
    send_bytes(f);
    idle(2);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL em_status done=%b hold=%b err=%b want 1 0 0", done, cpu_hold, err); end
    checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL em_nwrites got=%0d want=0", wr_addr.size()); end
  endtask

  task automatic test_throttle();
    logic [7:0] f[$];
    pulse_start();
    f = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (f[i]) begin
      send_byte(f[i]);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (i == 5) begin
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'd0 || bus.mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL th_latency we=%b addr=%h data=%h want 1 00 deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      end
    end
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL th_pulse_width we=%b want=0", bus.mem_we); end
    send_byte(8'h38);
    idle(2);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL th_done got=%b want=1", done); end
    checks++; if (wr_addr.size() != 1 || wr_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL th_write n=%0d data=%h want 1 deadbeef", wr_addr.size(), wr_data[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] f[$];
    pulse_start();
    f = {8'h00, 8'h02, 8'h20, 8'h08};
    send_bytes(f);
    // Reset with a pending transfer and a start pulse in the same cycle.
    @(negedge clk);
    bus.rx_data = 8'h00;
    resetpc = 1'b1;
    start = 1'b1;
    @(negedge clk);
    resetpc = 1'b0;
    start = 1'b0;
    idle(3);
    checks++; if (busy !== 1'b0 || bus.rx_ready !== 1'b0) begin failures++; $display("FAIL rm_idle busy=%b rdy=%b want 0 0", busy, bus.rx_ready); end
    checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL rm_nwrites got=%0d want=0", wr_addr.size()); end
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rm_status hold=%b done=%b err=%b want 1 0 0", cpu_hold, done, err); end
    checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rm_wdata got=%h want=0", bus.mem_wdata); end
  endtask

  task automatic test_restart();
    logic [7:0] f[$];
    pulse_start();
    f = {8'h00, 8'h01, 8'hDE, 8'hAD};
    send_bytes(f);
    idle(1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rs_busy_start got=%b want=1", busy); end
    f = {8'hBE, 8'hEF, 8'h38};
    send_bytes(f);
    idle(2);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL rs_first done=%b err=%b want 1 0", done, err); end
    checks++; if (wr_addr.size() != 1 || wr_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL rs_first_w n=%0d data=%h want 1 deadbeef", wr_addr.size(), wr_data[0]); end
    pulse_start();
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rs_reload done=%b hold=%b busy=%b want 0 1 1", done, cpu_hold, busy); end
    f = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    send_bytes(f);
    idle(2);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL rs_second done=%b hold=%b want 1 0", done, cpu_hold); end
    checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h11223344) begin failures++; $display("FAIL rs_second_w n=%0d addr=%h data=%h want 1 00 11223344", wr_addr.size(), wr_addr[0], wr_data[0]); end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_two_word();
    test_bad_csum();
    test_oversize();
    test_empty();
    test_throttle();
    test_reset_mid();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side companion of the instruction memory: receives a byte stream (UART or debug link), assembles big-endian 32-bit MIPS words, and drives the instruction memory write port at word addresses 0..N-1.
- Holds the CPU in reset (cpu_hold feeds the core's PC reset) until a complete image passes its checksum.
- Sits between the byte receiver and the instruction memory/core reset.

Parameters:
INST_DEPTH, 256, instruction memory depth in 32-bit words; AW = $clog2(INST_DEPTH) is the address width.

Ports:
clk  input  1  system clock, all logic on rising edge
resetpc  input  1  synchronous active-high reset
start  input  1  one-cycle pulse: begin a new load session
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready)
mem_we  output  1  instruction memory write enable, 1-cycle pulse
mem_addr  output  AW  word address of write
mem_wdata  output  32  word to write
cpu_hold  output  1  keep core in reset; 1 = held
busy  output  1  session in progress
done  output  1  image loaded and checksum good (sticky)
err  output  1  session failed (sticky)

Behaviour:
- Frame format:
  - 2-byte word count N, big-endian (hi byte first).
  - 4*N data bytes; each word is big-endian (first byte is wdata[31:24]).
  - 1 checksum byte = sum mod 256 of all data bytes (header excluded).
- States: IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
- Reset values: state IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, err=0; internal byte index, word index, and checksum accumulator all 0.
- rx_ready=1 only in HDR_HI, HDR_LO, DATA, CSUM; rx_valid is ignored in all other states. busy=1 in exactly those states.
- start accepted only in IDLE, DONE, ERR. On start:
  - go to HDR_HI;
  - clear done, err, word index, byte index, accumulator;
  - set cpu_hold=1.
  - start while busy is ignored.
- HDR_HI: on transfer, latch count[15:8] and go to HDR_LO.
- HDR_LO: on transfer, latch count[7:0], then:
  - count > INST_DEPTH: go to ERR, no writes performed.
  - count == 0: go to CSUM.
  - otherwise: go to DATA.
- DATA:
  - Each transfer shifts the byte into the word register and adds it to the accumulator (8-bit wrap).
  - On the 4th byte of a word: next cycle mem_we=1 for exactly one cycle, with mem_addr = word index and mem_wdata = assembled word. Word index then increments.
  - After the write of word N-1, go to CSUM.
  - Write latency: 1 cycle after the accepting edge. Back-to-back bytes at full rate are supported with no stalls; rx_ready stays 1 throughout DATA.
- CSUM: on transfer, compare byte with accumulator:
  - equal: go to DONE;
  - not equal: go to ERR.
- DONE: done=1, cpu_hold=0, rx_ready=0.
- ERR: err=1, cpu_hold=1, rx_ready=0. Memory contents already written are left as-is (partial image).
- mem_addr holds its last value when mem_we=0. mem_wdata holds the last assembled word.
- resetpc mid-session:
  - return to IDLE with all reset values, cpu_hold=1;
  - any partial word is discarded and no write pulse is issued.
- resetpc has priority over start and over any transfer in the same cycle.

Test Plan:
- Reset then idle: resetpc 2 cycles, rx_valid=1 with data 0xAA -> rx_ready=0, no mem_we, cpu_hold=1, done=err=0.
- Two-word load: start; stream 00 02 | 20 08 00 05 | 00 00 00 0C | checksum 0x39 -> mem_we pulse at addr 0 data 0x20080005, pulse at addr 1 data 0x0000000C; done=1, cpu_hold=0.
- Bad checksum: same frame with checksum 0x38 -> both writes still occur; err=1, done=0, cpu_hold=1.
- Oversize header: with INST_DEPTH=256, send 01 01 (257) -> ERR immediately, zero mem_we pulses, rx_ready=0.
- Empty image and throttling: header 00 00 then checksum 00 -> done=1 with no writes. Separately, a 1-word frame with rx_valid toggling every other cycle -> correct word 0xDEADBEEF written at addr 0.
- Reset mid-word and restart: resetpc after 2 data bytes -> no write, state IDLE. A later start during busy is ignored; start after DONE clears done and reloads from addr 0.
